// File: rtl/che_pkt_tx_if.sv
// Word stream from the CHE transmitter toward the radio/packet buffer.
// The master drives data/valid/last; the slave returns ready.
interface che_pkt_tx_if #(
  parameter int WORD_WIDTH = 16
) ();
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/che_pkt_tx.sv
// CHE advertisement serializer: header, CH ID, hops, Q-value onto a valid/ready stream.
// Build option CHE_CHECKSUM_EN appends a mod-2^16 checksum word after the Q-value.
module che_pkt_tx #(
  parameter int                    WORD_WIDTH   = 16,
  parameter logic [7:0]            PKT_TYPE_CHE = 8'h02,
  parameter logic [WORD_WIDTH-1:0] HOP_LIMIT    = 16'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relay,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsfromCH,
  input  logic [WORD_WIDTH-1:0] chQValue,
  input  logic                  HB_reset,
  che_pkt_tx_if.master          tx,
  output logic                  busy,
  output logic                  done,
  output logic                  dropped
);

`ifdef CHE_CHECKSUM_EN
  localparam logic [7:0] WORD_COUNT = 8'd5;
`else
  localparam logic [7:0] WORD_COUNT = 8'd4;
`endif
  localparam logic [WORD_WIDTH-1:0] HEADER = WORD_WIDTH'({PKT_TYPE_CHE, WORD_COUNT});

  typedef enum logic [2:0] {IDLE, CHECK, HDR, ID, HOPS, QV, CHK, DONE} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] snap_id;
  logic [WORD_WIDTH-1:0] snap_hops;
  logic [WORD_WIDTH-1:0] snap_q;
  logic [WORD_WIDTH-1:0] relay_hops;
  logic                  accept;

  // Saturate so an unreachable CH (all ones) stays unreachable and is always dropped.
  assign relay_hops = (&hopsfromCH) ? hopsfromCH : hopsfromCH + 1'b1;
  assign accept     = tx.tx_valid & tx.tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      snap_id     <= '0;
      snap_hops   <= '0;
      snap_q      <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      tx.tx_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dropped     <= 1'b0;
    end else if (HB_reset) begin
      state       <= IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      done    <= 1'b0;
      dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_id   <= relay ? chosenCH : myNodeID;
            snap_hops <= relay ? relay_hops : '0;
            snap_q    <= relay ? chQValue : myQValue;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (snap_hops > HOP_LIMIT) begin
            dropped <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tx.tx_data  <= HEADER;
            tx.tx_valid <= 1'b1;
            state       <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            tx.tx_data <= snap_id;
            state      <= ID;
          end
        end
        ID: begin
          if (accept) begin
            tx.tx_data <= snap_hops;
            state      <= HOPS;
          end
        end
        HOPS: begin
          if (accept) begin
            tx.tx_data <= snap_q;
`ifndef CHE_CHECKSUM_EN
            tx.tx_last <= 1'b1;
`endif
            state      <= QV;
          end
        end
        QV: begin
          if (accept) begin
`ifdef CHE_CHECKSUM_EN
            tx.tx_data <= HEADER + snap_id + snap_hops + snap_q;
            tx.tx_last <= 1'b1;
            state      <= CHK;
`else
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
`endif
          end
        end
`ifdef CHE_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_che_pkt_tx.sv
// Bench for che_pkt_tx: directed vector table, hand-built abort/reset sequences,
// and randomized packets with random backpressure checked against a packet-level model.
module tb_che_pkt_tx;
  localparam int W = 16;
`ifdef CHE_CHECKSUM_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif
  localparam logic [15:0] HDR = 16'h0200 | 16'(NW);

  logic        clk = 1'b0;
  logic        rst, start, relay, hb;
  logic [15:0] my_id, my_q, ch, hf, chq;
  logic        busy, done, dropped;

  int total = 0;
  int bad   = 0;

  logic [15:0] got_w[$];
  logic        got_l[$];
  bit          saw_drop, saw_done;
  int          first_v, nstall;

  typedef struct {
    logic        r;
    logic [15:0] a, b, c;
    bit          drop;
    logic [15:0] eh;
  } vec_t;
  vec_t tv[6];

  logic        rr;
  logic [15:0] ra, rb, rc, ei, eh, eq;
  bit          ed;
  bit          any;

  che_pkt_tx_if #(.WORD_WIDTH(W)) tx ();

  che_pkt_tx dut (
    .clk(clk), .rst(rst), .start(start), .relay(relay),
    .myNodeID(my_id), .myQValue(my_q), .chosenCH(ch), .hopsfromCH(hf), .chQValue(chq),
    .HB_reset(hb), .tx(tx), .busy(busy), .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Packet-level reference: what should appear on air for one request.
  task automatic ref_model(input logic r, input logic [15:0] a, b, c,
                           output bit drop, output logic [15:0] id, h, q);
    int hh;
    hh = r ? ((int'(b) + 1 > 65535) ? 65535 : int'(b) + 1) : 0;
    drop = (hh > 8);
    id = a;
    h  = 16'(hh);
    q  = c;
  endtask

  task automatic run_pkt(input logic r, input logic [15:0] a, b, c,
                         input int ready_pct, input bit restart, input int stall_at);
    logic [15:0] pd;
    logic        pl;
    bit          stalled;
    got_w.delete();
    got_l.delete();
    saw_drop = 0; saw_done = 0; first_v = -1; nstall = 0; stalled = 0; pd = '0; pl = 0;
    @(negedge clk);
    start = 1'b1;
    relay = r;
    if (r) begin
      ch = a; hf = b; chq = c; my_id = 16'($urandom); my_q = 16'($urandom);
    end else begin
      my_id = a; my_q = c; ch = 16'($urandom); hf = 16'($urandom); chq = 16'($urandom);
    end
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
      // Spurious starts while busy plus scrambled inputs must not disturb the packet.
      start = restart && (i == 1 || i == 3);
      relay = 1'($urandom); my_id = 16'($urandom); my_q = 16'($urandom);
      ch = 16'($urandom); hf = 16'($urandom); chq = 16'($urandom);
      if (i == 1) chk("busy_after_start", busy, 1);
      if (stalled) begin
        chk("hold_valid", tx.tx_valid, 1);
        chk("hold_data", tx.tx_data, pd);
        chk("hold_last", tx.tx_last, pl);
      end
      if (tx.tx_valid && first_v < 0) first_v = i;
      if (dropped) saw_drop = 1;
      if (done) begin
        saw_done = 1;
        chk("done_no_valid", tx.tx_valid, 0);
        chk("busy_in_done", busy, 1);
      end
      if (saw_drop || saw_done) break;
      if (stall_at >= 0)
        tx.tx_ready = !(tx.tx_valid && got_w.size() == stall_at && nstall < 3);
      else
        tx.tx_ready = ($urandom_range(99) < ready_pct);
      if (tx.tx_valid && !tx.tx_ready) nstall++;
      stalled = tx.tx_valid && !tx.tx_ready;
      pd = tx.tx_data;
      pl = tx.tx_last;
      if (tx.tx_valid && tx.tx_ready) begin
        got_w.push_back(tx.tx_data);
        got_l.push_back(tx.tx_last);
      end
    end
    chk("pkt_end_seen", saw_drop | saw_done, 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_idle_after", busy, 0);
    chk("no_done_after", done, 0);
  endtask

  task automatic cmp_pkt(input string tag, input bit exp_drop, input logic [15:0] id, h, q);
    logic [15:0] e[5];
    logic [15:0] sum;
    sum = HDR + id + h + q;
    e = '{HDR, id, h, q, sum};
    chk({tag, "_drop"}, saw_drop, exp_drop);
    if (exp_drop) begin
      chk({tag, "_novalid"}, first_v == -1, 1);
    end else begin
      chk({tag, "_done"}, saw_done, 1);
      chk({tag, "_first_valid"}, first_v, 2);
      chk({tag, "_len"}, got_w.size(), NW);
      for (int k = 0; k < NW && k < got_w.size(); k++) begin
        chk({tag, "_word"}, got_w[k], e[k]);
        chk({tag, "_last"}, got_l[k], k == NW - 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relay = 1'b0; hb = 1'b0;
    my_id = '0; my_q = '0; ch = '0; hf = '0; chq = '0;
    tx.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", tx.tx_data, 0);
    chk("rst_valid", tx.tx_valid, 0);
    chk("rst_last", tx.tx_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dropped", dropped, 0);
    rst = 1'b0;

    tv[0] = '{1'b0, 16'd12, 16'd0,     16'h4000, 1'b0, 16'd0};
    tv[1] = '{1'b1, 16'd23, 16'd2,     16'h3000, 1'b0, 16'd3};
    tv[2] = '{1'b1, 16'd23, 16'd8,     16'h1234, 1'b1, 16'd0};
    tv[3] = '{1'b1, 16'd5,  16'hFFFF,  16'h0001, 1'b1, 16'd0};
    tv[4] = '{1'b1, 16'd7,  16'd7,     16'h2222, 1'b0, 16'd8};
    tv[5] = '{1'b1, 16'd9,  16'd0,     16'hBEEF, 1'b0, 16'd1};
    for (int i = 0; i < 6; i++) begin
      run_pkt(tv[i].r, tv[i].a, tv[i].b, tv[i].c, 100, i == 1, -1);
      cmp_pkt("vec", tv[i].drop, tv[i].a, tv[i].eh, tv[i].c);
    end

    // Three-cycle stall on the ID word.
    run_pkt(1'b1, 16'd23, 16'd2, 16'h3000, 100, 1'b0, 1);
    cmp_pkt("bp", 1'b0, 16'd23, 16'd3, 16'h3000);
    chk("bp_stall_cycles", nstall, 3);

    // Heartbeat abort while the hops word is on the bus.
    @(negedge clk);
    start = 1'b1; relay = 1'b0; my_id = 16'd12; my_q = 16'h4000; tx.tx_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_at_hops", tx.tx_data, 0);
    chk("abort_valid_before", tx.tx_valid, 1);
    hb = 1'b1;
    @(negedge clk); hb = 1'b0;
    chk("abort_valid", tx.tx_valid, 0);
    chk("abort_last", tx.tx_last, 0);
    chk("abort_busy", busy, 0);
    any = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any |= done | dropped | tx.tx_valid | busy;
    end
    chk("abort_quiet", any, 0);
    run_pkt(1'b0, 16'd12, 16'd0, 16'h4000, 100, 1'b0, -1);
    cmp_pkt("post_abort", 1'b0, 16'd12, 16'd0, 16'h4000);

    // Heartbeat reset and start together: start is lost.
    @(negedge clk);
    start = 1'b1; hb = 1'b1; relay = 1'b0; my_id = 16'd44;
    @(negedge clk); start = 1'b0; hb = 1'b0;
    chk("hb_start_busy", busy, 0);
    any = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any |= tx.tx_valid | busy | done;
    end
    chk("hb_start_quiet", any, 0);

    // Synchronous reset mid-packet.
    @(negedge clk);
    start = 1'b1; relay = 1'b1; ch = 16'd31; hf = 16'd1; chq = 16'h0101; tx.tx_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_valid_before", tx.tx_valid, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_data", tx.tx_data, 0);
    chk("rst_mid_valid", tx.tx_valid, 0);
    chk("rst_mid_last", tx.tx_last, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);

    // Randomized requests with random backpressure.
    for (int n = 0; n < 60; n++) begin
      rr = 1'($urandom);
      ra = 16'($urandom);
      rb = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(10));
      if ($urandom_range(9) == 0) rb = 16'hFFFF;
      rc = 16'($urandom);
      ref_model(rr, ra, rb, rc, ed, ei, eh, eq);
      run_pkt(rr, ra, rb, rc, 30 + $urandom_range(70), 1'($urandom), -1);
      cmp_pkt("rnd", ed, ei, eh, eq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/che_pkt_tx.md
Name: che_pkt_tx

Overview:
- Transmit side of the cluster-head exchange (CHE) interface.
- Serializes one CHE advertisement (CH ID, hop count, Q-value) into a word stream toward the radio/packet buffer, using a valid/ready handshake.
- Two sources:
  - Own-CH mode: a node that elected itself CH advertises with hops = 0.
  - Relay mode: a member node forwards its chosen CH with hops incremented by one.
- The stream feeds the same packet path whose receive end supplies fCH_ID/fCH_Hops/fCH_QValue to the known-CH table.

Parameters:
- WORD_WIDTH, 16, width of every packet word and field
- PKT_TYPE_CHE, 8'h02, packet type code placed in header bits [15:8]
- HOP_LIMIT, 16'd8, maximum hop count allowed on air; relays exceeding it are dropped

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to send a CHE packet; ignored while busy
- relay  input  1  sampled with start: 0 = own-CH advert, 1 = relay chosen CH
- myNodeID  input  WORD_WIDTH  own node ID, used when relay=0
- myQValue  input  WORD_WIDTH  own Q-value (Q2.14), used when relay=0
- chosenCH  input  WORD_WIDTH  selected CH ID, used when relay=1
- hopsfromCH  input  WORD_WIDTH  hops to chosen CH, used when relay=1
- chQValue  input  WORD_WIDTH  chosen CH Q-value, used when relay=1
- HB_reset  input  1  heartbeat reset; aborts any packet in progress
- tx_data  output  WORD_WIDTH  current packet word
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts word when tx_valid & tx_ready
- tx_last  output  1  marks final word of packet, qualified by tx_valid
- busy  output  1  high from accepted start until return to IDLE
- done  output  1  one-cycle pulse after final word handshake
- dropped  output  1  one-cycle pulse when a relay is suppressed by HOP_LIMIT

Behaviour:
- Reset values: tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, dropped=0, state=IDLE, snapshot registers=0.
- States: IDLE, CHECK, HDR, ID, HOPS, QV, [CHK], DONE.
- IDLE:
  - On start=1, snapshot field values into registers; go to CHECK; busy=1 from the next cycle.
  - Snapshot when relay=0: ID=myNodeID, hops=0, Q=myQValue.
  - Snapshot when relay=1: ID=chosenCH, hops=hopsfromCH+1 saturating at 16'hFFFF (hopsfromCH=16'hFFFF stays 16'hFFFF), Q=chQValue.
- CHECK (one cycle):
  - If snapshot hops > HOP_LIMIT: pulse dropped, go to IDLE, emit no words.
  - Otherwise go to HDR.
  - First tx_valid therefore appears 2 cycles after start.
- HDR, ID, HOPS, QV:
  - Present the word with tx_valid=1.
  - Advance only on tx_valid & tx_ready.
  - Hold tx_data/tx_last stable while tx_ready=0.
  - Back-to-back acceptance gives 1 word per cycle.
- Word order:
  - Header: {PKT_TYPE_CHE, 8-bit word count} (4, or 5 with the optional feature).
  - ID.
  - Hops.
  - Q-value.
- tx_last=1 on the final word only.
- DONE (one cycle): tx_valid=0, done=1, then IDLE; busy drops in the same cycle as the return to IDLE.
- start while busy: ignored; no queuing.
- HB_reset=1 in any state: next cycle state=IDLE, tx_valid=0, tx_last=0, busy=0; no done, no dropped.
- HB_reset and start in the same cycle: HB_reset wins; start is ignored.
- rst mid-packet: all outputs return to reset values on the next edge.
- Input changes after start do not affect an in-flight packet.
- Receiver-side convention preserved: hops=16'hFFFF means unreachable and is never transmitted, because it always exceeds HOP_LIMIT.

Optional Feature:
- Macro CHE_CHECKSUM_EN.
- Defined:
  - Header count = 5.
  - State CHK follows QV and appends a checksum word = (header + ID + hops + Q) mod 2^16.
  - tx_last moves to the CHK word.
- Undefined: header count = 4, CHK state absent, tx_last on the QV word.

Test Plan:
- Own-CH advert: myNodeID=12, myQValue=16'h4000, relay=0, tx_ready=1 → words 16'h0204, 12, 0, 16'h4000; tx_last on 4th word; done 1 cycle later; first valid 2 cycles after start.
- Relay: chosenCH=23, hopsfromCH=2, chQValue=16'h3000 → words 16'h0204, 23, 3, 16'h3000.
- Backpressure: tx_ready low 3 cycles on the ID word → tx_data holds 23 and tx_valid stays high; stream resumes with no word lost or duplicated.
- Hop limit: relay with hopsfromCH=8 → dropped pulse, no tx_valid. Relay with hopsfromCH=16'hFFFF → dropped.
- Abort: HB_reset=1 during HOPS → tx_valid=0 next cycle, busy=0, no done. A new start then sends a complete packet. A start issued while busy is ignored.
- With CHE_CHECKSUM_EN, own-CH advert as in the first scenario → header 16'h0205, fifth word 16'h0205+12+0+16'h4000 = 16'h4211 with tx_last.
